// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the single-outstanding Wishbone initiator.
// The watchdog is enabled by defining WB_TIMEOUT_EN.
package wb_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned TIMEOUT_W           = 16;
  localparam logic [31:0] ABORT_RDATA_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TIMER_BASE          = 32'h3002_0000;

  // Terminal count for a watchdog that allows `cycles` BUS cycles; clamped to the legal range.
  function automatic logic [TIMEOUT_W-1:0] terminal_count(input int unsigned cycles);
    int unsigned c;
    c = cycles;
    if (c < 32'd2) begin
      c = 32'd2;
    end else if (c > 32'd65535) begin
      c = 32'd65535;
    end else begin
      c = cycles;
    end
    return TIMEOUT_W'(c - 32'd1);
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Saturating watchdog counter for wb_initiator; clear has priority over enable.
// Instantiated only when WB_TIMEOUT_EN is defined.
module wb_timeout_cnt
  import wb_initiator_pkg::*;
#(
  parameter logic [TIMEOUT_W-1:0] TERMINAL = 16'd15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = {TIMEOUT_W{1'b1}};

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {TIMEOUT_W{1'b0}};
    end else if (clr) begin
      count <= {TIMEOUT_W{1'b0}};
    end else if (en && (count != CNT_MAX)) begin
      count <= count + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign tc = (count == TERMINAL);

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: core request -> one bus cycle -> response.
// Define WB_TIMEOUT_EN to add a watchdog that aborts cycles after TIMEOUT_CYCLES.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ABORT_RDATA    = ABORT_RDATA_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic [31:0] wbm_dat_i
);

  state_t state;
  logic   timeout_hit;

`ifdef WB_TIMEOUT_EN
  logic accept;
  logic in_bus;

  assign accept = (state == IDLE) && req_valid_i && req_ready_o;
  assign in_bus = (state == BUS);

  wb_timeout_cnt #(
    .TERMINAL(terminal_count(TIMEOUT_CYCLES))
  ) u_timeout_cnt (
    .clk  (clk_i),
    .rst_n(rstn_i),
    .clr  (accept),
    .en   (in_bus),
    .tc   (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Control FSM; every output is a register. Async reset drops cyc/stb immediately.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 32'h0000_0000;
      rsp_err_o   <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= 32'h0000_0000;
      wbm_dat_o   <= 32'h0000_0000;
      wbm_sel_o   <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            wbm_we_o    <= req_we_i;
            wbm_adr_o   <= req_addr_i;
            wbm_dat_o   <= req_wdata_i;
            wbm_sel_o   <= req_be_i;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            req_ready_o <= 1'b0;
            state       <= BUS;
          end else begin
            req_ready_o <= 1'b1;
          end
        end
        BUS: begin
          // Priority: err, then ack, then watchdog expiry.
          if (wbm_err_i) begin
            rsp_err_o   <= 1'b1;
            rsp_rdata_o <= ABORT_RDATA;
            rsp_valid_o <= 1'b1;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            state       <= RESP;
          end else if (wbm_ack_i) begin
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= wbm_we_o ? 32'h0000_0000 : wbm_dat_i;
            rsp_valid_o <= 1'b1;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            state       <= RESP;
          end else if (timeout_hit) begin
            rsp_err_o   <= 1'b1;
            rsp_rdata_o <= ABORT_RDATA;
            rsp_valid_o <= 1'b1;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            state       <= RESP;
          end else begin
            state <= BUS;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end else begin
            state <= RESP;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b0;
          rsp_valid_o <= 1'b0;
          wbm_cyc_o   <= 1'b0;
          wbm_stb_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator with a timer-like Wishbone responder and a reference model.
`timescale 1ns/1ps
module tb_wb_initiator;
  import wb_initiator_pkg::*;

  localparam int unsigned TMO   = 8;
  localparam logic [31:0] ABORT = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        wbm_cyc, wbm_stb, wbm_we;
  logic [31:0] wbm_adr, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel;
  logic        wbm_ack, wbm_err;

  wb_initiator #(.TIMEOUT_CYCLES(TMO), .ABORT_RDATA(ABORT)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we), .wbm_adr_o(wbm_adr),
    .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel),
    .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err), .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  // Responder: acks/errs cfg_lat edges after stb rises (0 = never); timer at TIMER_BASE counts every cycle.
  int          cfg_lat = 1;
  logic        cfg_ack = 1'b1;
  logic        cfg_err = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;
  logic        stray_ack = 1'b0;
  logic        ack_r = 1'b0;
  logic        err_r = 1'b0;
  logic [31:0] timer_val = 32'h0;
  int          bus_cnt = 0;
  int          last_ack_cyc = 0;

  assign wbm_ack   = ack_r | stray_ack;
  assign wbm_err   = err_r;
  assign wbm_dat_i = (wbm_adr == TIMER_BASE) ? timer_val : cfg_rdata;

  always @(posedge clk) begin
    ack_r     <= 1'b0;
    err_r     <= 1'b0;
    timer_val <= timer_val + 32'd1;
    if (ack_r) last_ack_cyc <= cyc_no;
    if (wbm_cyc && wbm_stb && !ack_r && !err_r) begin
      bus_cnt <= bus_cnt + 1;
      if (cfg_lat != 0 && bus_cnt + 1 == cfg_lat) begin
        ack_r <= cfg_ack;
        err_r <= cfg_err;
        if (cfg_ack && !cfg_err && wbm_we && wbm_adr == TIMER_BASE) timer_val <= wbm_dat_o;
      end
    end else if (!wbm_cyc) begin
      bus_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One request with rsp_ready high; reports response, latency (accept edge = tick 1) and cyc-high cycles.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rdata, output logic err,
                         output int ticks, output int cyc_hi, output int acc_cyc);
    logic fields_ok;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = 1'b1;
    acc_cyc = cyc_no;
    tick();
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom; req_be = ~be;
    ticks = 1; cyc_hi = 0; fields_ok = 1'b1;
    while (!rsp_valid && ticks < 200) begin
      if (wbm_cyc) cyc_hi++;
      if (wbm_stb !== wbm_cyc || wbm_adr !== addr || wbm_we !== we ||
          wbm_dat_o !== wdata || wbm_sel !== be) fields_ok = 1'b0;
      tick();
      ticks++;
    end
    check("rsp_arrived", 32'(rsp_valid), 32'd1);
    check("bus_fields_stable", 32'(fields_ok), 32'd1);
    rdata = rsp_rdata;
    err = rsp_err;
    tick();
  endtask

  logic [31:0] rd, exp_rd, snap;
  logic        er, we_r, exp_err;
  logic [31:0] a_r, d_r;
  int          tk, ch, acc0, acc1, wa, ra, lat, cnt, seen;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_wbm_ctrl", {28'd0, wbm_cyc, wbm_stb, wbm_we, 1'b0}, 32'd0);
    check("rst_wbm_adr", wbm_adr, 32'd0);
    check("rst_wbm_dat", wbm_dat_o, 32'd0);
    check("rst_wbm_sel", 32'(wbm_sel), 32'd0);
    rstn = 1'b1;
    tick();
    check("req_ready_after_rst", 32'(req_ready), 32'd1);

    // Stray ack in IDLE is ignored
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    tick();
    check("stray_ack_rsp", 32'(rsp_valid), 32'd0);
    check("stray_ack_cyc", 32'(wbm_cyc), 32'd0);
    check("stray_ack_ready", 32'(req_ready), 32'd1);

    // Timer write then read back
    cfg_lat = 1; cfg_ack = 1'b1; cfg_err = 1'b0;
    run_txn(1'b1, TIMER_BASE, 32'h0000_0100, 4'hF, rd, er, tk, ch, acc0);
    wa = last_ack_cyc;
    check("timer_wr_err", 32'(er), 32'd0);
    check("timer_wr_rdata", rd, 32'd0);
    check("timer_wr_lat", 32'(tk), 32'd3);
    run_txn(1'b0, TIMER_BASE, 32'h0, 4'hF, rd, er, tk, ch, acc1);
    ra = last_ack_cyc;
    check("timer_rd_err", 32'(er), 32'd0);
    check("timer_rd_data", rd, 32'h0000_0100 + 32'(ra - wa));
    check("initiation_interval", 32'(acc1 - acc0), 32'd4);

    // Reads take exactly 3 cycles with 2 cycles of cyc
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b0, TIMER_BASE, 32'h0, 4'hF, rd, er, tk, ch, acc0);
      check("rd_lat3", 32'(tk), 32'd3);
      check("rd_cyc2", 32'(ch), 32'd2);
    end

    // Response backpressure with a pending request
    cfg_rdata = 32'hCAFE_0001;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4000_0010; req_be = 4'hF;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4000_0020; req_wdata = 32'h1234_5678; req_be = 4'h3;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, 32'hCAFE_0001);
      check("bp_err", 32'(rsp_err), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_ready", 32'(req_ready), 32'd1);
    check("bp_not_yet_cyc", 32'(wbm_cyc), 32'd0);
    tick();
    req_valid = 1'b0;
    check("bp_pending_accepted", 32'(wbm_cyc), 32'd1);
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check("bp_wr_rdata", rsp_rdata, 32'd0);
    check("bp_wr_err", 32'(rsp_err), 32'd0);
    tick();

    // err together with ack
    cfg_lat = 1; cfg_ack = 1'b1; cfg_err = 1'b1; cfg_rdata = 32'h5555_AAAA;
    run_txn(1'b0, 32'h4000_0030, 32'h0, 4'hF, rd, er, tk, ch, acc0);
    check("err_ack_err", 32'(er), 32'd1);
    check("err_ack_rdata", rd, ABORT);

    // ack on the watchdog's last cycle
    cfg_lat = int'(TMO) - 1; cfg_ack = 1'b1; cfg_err = 1'b0; cfg_rdata = 32'h0BAD_F00D;
    run_txn(1'b0, 32'h4000_0040, 32'h0, 4'hF, rd, er, tk, ch, acc0);
    check("ack_at_tmo_err", 32'(er), 32'd0);
    check("ack_at_tmo_data", rd, 32'h0BAD_F00D);
    check("ack_at_tmo_cyc", 32'(ch), 32'(TMO));

    // Unmapped address: no responder
    cfg_lat = 0;
`ifdef WB_TIMEOUT_EN
    run_txn(1'b0, 32'h3003_0000, 32'h0, 4'hF, rd, er, tk, ch, acc0);
    check("tmo_cyc_hi", 32'(ch), 32'(TMO));
    check("tmo_err", 32'(er), 32'd1);
    check("tmo_rdata", rd, ABORT);
`else
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3003_0000;
    tick();
    req_valid = 1'b0;
    cnt = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (wbm_cyc) cnt++;
      if (rsp_valid) seen = 1;
      tick();
    end
    check("notmo_cyc_hi", 32'(cnt), 32'd100);
    check("notmo_no_rsp", 32'(seen), 32'd0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
`endif

    // Reset asserted in the middle of a bus cycle
    cfg_lat = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4000_0050;
    tick();
    req_valid = 1'b0;
    tick();
    check("midrst_in_bus", 32'(wbm_cyc), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("midrst_cyc_async", 32'(wbm_cyc), 32'd0);
    check("midrst_stb_async", 32'(wbm_stb), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    tick();
    rstn = 1'b1;
    tick();
    check("midrst_idle_ready", 32'(req_ready), 32'd1);
    check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    cfg_lat = 1; cfg_ack = 1'b1; cfg_err = 1'b0;
    run_txn(1'b0, TIMER_BASE, 32'h0, 4'hF, rd, er, tk, ch, acc0);
    check("midrst_next_err", 32'(er), 32'd0);
    check("midrst_next_lat", 32'(tk), 32'd3);

    // Randomized transactions against the reference rules
    for (int i = 0; i < 20; i++) begin
      we_r = 1'($urandom_range(0, 1));
      a_r = {16'h4000, 16'($urandom)};
      d_r = $urandom;
      lat = int'($urandom_range(1, 7));
      cfg_lat = lat;
      cfg_err = ($urandom_range(0, 4) == 0);
      cfg_ack = cfg_err ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_rdata = $urandom;
      exp_err = cfg_err;
      exp_rd = exp_err ? ABORT : (we_r ? 32'd0 : cfg_rdata);
      run_txn(we_r, a_r, d_r, 4'($urandom), rd, er, tk, ch, acc0);
      check("rand_err", 32'(er), 32'(exp_err));
      check("rand_rdata", rd, exp_rd);
      check("rand_lat", 32'(tk), 32'(lat + 2));
      check("rand_cyc_hi", 32'(ch), 32'(lat + 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
# wb_initiator

Single-outstanding Wishbone classic initiator that turns a core-side valid/ready load/store request into one bus cycle, then returns read data and error status on a response channel. It sits between the rvj1 core data port and the user-area Wishbone interconnect, and drives responders such as the timer at 0x3002_0000. An optional watchdog aborts cycles that are never acknowledged.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in BUS before abort; legal range 2..65535.
- ABORT_RDATA, 32'h0000_0000: value returned on rsp_rdata_o for an aborted or errored read.

Ports:
- clk_i  in  1  single clock; all logic on posedge.
- rstn_i  in  1  asynchronous, active-low reset; one clock domain.
- req_valid_i  in  1  core request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_we_i  in  1  1=write, 0=read.
- req_addr_i  in  32  byte address, passed unchanged to the bus.
- req_wdata_i  in  32  write data.
- req_be_i  in  4  byte enables.
- rsp_valid_o  out  1  response valid; held until rsp_ready_i.
- rsp_ready_i  in  1  core accepts response.
- rsp_rdata_o  out  32  read data (writes: 0).
- rsp_err_o  out  1  bus error or timeout.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone strobes.
- wbm_adr_o  out  32; wbm_dat_o  out  32; wbm_sel_o  out  4.
- wbm_ack_i  in  1; wbm_err_i  in  1; wbm_dat_i  in  32.

## Operation
- FSM states: IDLE, BUS, RESP. Reset state IDLE.
- IDLE: req_ready_o=1. On req_valid_i, register we/addr/wdata/be into wbm_* and enter BUS. No other output toggles.
- BUS: wbm_cyc_o=wbm_stb_o=1, request fields stable; req_ready_o=0; the timeout counter increments every cycle.
  - wbm_err_i=1 → rsp_err_o=1, rsp_rdata_o=ABORT_RDATA; go to RESP. err wins over simultaneous ack.
  - wbm_ack_i=1 (no err) → rsp_rdata_o=wbm_dat_i for reads, 0 for writes; rsp_err_o=0; go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack/err (WB_TIMEOUT_EN only) → rsp_err_o=1, rsp_rdata_o=ABORT_RDATA; go to RESP. An ack in that same cycle wins over the timeout.
- RESP: cyc/stb=0, rsp_valid_o=1, data/err stable. When rsp_ready_i=1, return to IDLE. A new request is not accepted in that cycle.
- ack/err outside BUS is ignored.
- Counter clears on every entry to BUS. It is 16 bits wide and saturates; it never wraps.

## Timing
- Reset values: req_ready_o=0 while rstn_i low, 1 from the first clock edge after release. All other outputs are 0: rsp_valid_o, rsp_rdata_o, rsp_err_o, and every wbm_* output.
- Assertion of rstn_i during BUS drops wbm_cyc_o and wbm_stb_o asynchronously. No response is produced.
- Request handshake at edge N → cyc/stb high for the cycle after N.
- Ack sampled at edge M → cyc/stb low and rsp_valid_o high for the cycle after M.
- Against the timer (acks one cycle after stb): 3 cycles from request accept to rsp_valid_o. Minimum initiation interval is 4 cycles when rsp_ready_i is tied high.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- WB_TIMEOUT_EN defined: watchdog and counter are present, and BUS is exited after at most TIMEOUT_CYCLES cycles.
- WB_TIMEOUT_EN undefined: the counter is not instantiated. BUS waits indefinitely for ack or err, and TIMEOUT_CYCLES is ignored.

## Structure
- Package wb_initiator_pkg holds:
  - the state typedef (IDLE/BUS/RESP);
  - TIMEOUT_W=16;
  - default ABORT_RDATA;
  - the timer base constant 32'h3002_0000 for benches.
- Sub-module wb_timeout_cnt: clear/enable/saturating counter with a terminal-count output. It is instantiated only under WB_TIMEOUT_EN.

## Test plan
- Write then read the timer: write 0x0000_0100 to 0x3002_0000, then read it back.
  - Write completes with rsp_err_o=0.
  - Read rdata = 0x100 plus the elapsed cycles between the two acks (exact count checked by the bench).
- Reads are fixed at 3 cycles: with rsp_ready_i=1, each read reaches rsp_valid_o exactly 3 cycles after acceptance. Each request sees cyc high for exactly 2 cycles.
- Response backpressure: hold rsp_ready_i=0 for 5 cycles.
  - rsp_valid_o, rsp_rdata_o and rsp_err_o stay stable.
  - req_ready_o=0 throughout.
  - A pending req_valid_i is accepted 1 cycle after rsp_ready_i rises.
- Timeout (WB_TIMEOUT_EN, TIMEOUT_CYCLES=8): read unmapped 0x3003_0000.
  - cyc high exactly 8 cycles.
  - rsp_err_o=1, rsp_rdata_o=ABORT_RDATA.
  - With the macro off, cyc stays high for 100 cycles and no response appears.
- Error and simultaneous events:
  - wbm_err_i with wbm_ack_i in the same cycle → rsp_err_o=1.
  - Ack on the timeout cycle → rsp_err_o=0 and the data is returned.
- Mid-cycle reset: drive rstn_i low during BUS.
  - cyc/stb fall with no clock edge.
  - After release: IDLE, no rsp_valid_o, and the next request completes normally.
